// File: rtl/noc_pkt_pkg.sv
// rtl/noc_pkt_pkg.sv - flit geometry helpers, header bit offsets and FSM type for NoC packetizing
package noc_pkt_pkg;

    // Header bit offsets, counted down from the flit MSB
    localparam int VALID_BIT = 0;
    localparam int HEAD_BIT  = 1;
    localparam int TAIL_BIT  = 2;
    localparam int HDR_BITS  = 3;

    typedef enum logic {IDLE, SEND} pkt_state_t;

    function automatic int head_pay(input int flit_w, input int addr_w, input int vc_w);
        return flit_w - HDR_BITS - vc_w - addr_w;
    endfunction

    function automatic int body_pay(input int flit_w, input int vc_w);
        return flit_w - HDR_BITS - vc_w;
    endfunction

    function automatic int num_flits(input int w_in, input int flit_w, input int addr_w,
                                     input int vc_w);
        int hp;
        int bp;
        hp = head_pay(flit_w, addr_w, vc_w);
        bp = body_pay(flit_w, vc_w);
        if (w_in <= hp)
            return 1;
        return 1 + (w_in - hp + bp - 1) / bp;
    endfunction

endpackage

// File: rtl/flit_slicer.sv
// rtl/flit_slicer.sv - combinational formatter: word, dest, vc and flit index to one formatted flit
module flit_slicer
    import noc_pkt_pkg::*;
#(
    parameter int WIDTH_IN         = 64,
    parameter int FLIT_WIDTH       = 36,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int CNT_W            = 2
) (
    input  logic [WIDTH_IN-1:0]         data,
    input  logic [ADDRESS_WIDTH-1:0]    dest,
    input  logic [VC_ADDRESS_WIDTH-1:0] vc,
    input  logic [CNT_W-1:0]            cnt,
    output logic [FLIT_WIDTH-1:0]       flit
);

    localparam int HEAD_PAY  = head_pay(FLIT_WIDTH, ADDRESS_WIDTH, VC_ADDRESS_WIDTH);
    localparam int BODY_PAY  = body_pay(FLIT_WIDTH, VC_ADDRESS_WIDTH);
    localparam int NUM_FLITS = num_flits(WIDTH_IN, FLIT_WIDTH, ADDRESS_WIDTH, VC_ADDRESS_WIDTH);
    // One spare body slot of zeros keeps every slice in range, even for single-flit packets
    localparam int PAD_W     = HEAD_PAY + NUM_FLITS * BODY_PAY;
    localparam int VC_MSB    = FLIT_WIDTH - 1 - HDR_BITS;

    logic [PAD_W-1:0]    padded;
    logic [BODY_PAY-1:0] body;
    int                  shamt;

    always_comb begin
        padded = PAD_W'(data) << (PAD_W - WIDTH_IN);
        shamt  = (cnt == '0) ? 0 : HEAD_PAY + (int'(cnt) - 1) * BODY_PAY;
        body   = BODY_PAY'(padded >> (PAD_W - BODY_PAY - shamt));
        flit   = '0;
        flit[FLIT_WIDTH-1-VALID_BIT] = 1'b1;
        flit[FLIT_WIDTH-1-HEAD_BIT]  = (cnt == '0);
        flit[FLIT_WIDTH-1-TAIL_BIT]  = (int'(cnt) == NUM_FLITS - 1);
        flit[VC_MSB -: VC_ADDRESS_WIDTH] = vc;
        if (cnt == '0)
            flit[VC_MSB-VC_ADDRESS_WIDTH -: BODY_PAY] = {dest, padded[PAD_W-1 -: HEAD_PAY]};
        else
            flit[VC_MSB-VC_ADDRESS_WIDTH -: BODY_PAY] = body;
    end

endmodule

// File: rtl/packetizer_serial.sv
// rtl/packetizer_serial.sv - serialises one wide word per packet into head/body/tail flits for a narrow NoC link
module packetizer_serial
    import noc_pkt_pkg::*;
#(
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int WIDTH_IN         = 64,
    parameter int FLIT_WIDTH       = 36,
    parameter int VC_FROM_PORT     = 0,
    parameter int ASSIGNED_VC      = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH_IN-1:0]         i_data_in,
    input  logic [ADDRESS_WIDTH-1:0]    i_dest_in,
    input  logic [VC_ADDRESS_WIDTH-1:0] i_vc_in,
    input  logic                        i_valid_in,
    output logic                        i_ready_out,
    output logic [FLIT_WIDTH-1:0]       o_data_out,
    output logic                        o_valid_out,
    input  logic                        o_ready_in
);

    localparam int NUM_FLITS = num_flits(WIDTH_IN, FLIT_WIDTH, ADDRESS_WIDTH, VC_ADDRESS_WIDTH);
    localparam int CNT_W     = $clog2(NUM_FLITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_FLITS - 1);

    pkt_state_t                  state, state_next;
    logic [CNT_W-1:0]            cnt, cnt_next;
    logic [WIDTH_IN-1:0]         hold_data;
    logic [ADDRESS_WIDTH-1:0]    hold_dest;
    logic [VC_ADDRESS_WIDTH-1:0] hold_vc, in_vc;
    logic                        accept, load_flit, last_flit;
    logic [FLIT_WIDTH-1:0]       slice_flit;

    assign in_vc     = (VC_FROM_PORT != 0) ? i_vc_in : VC_ADDRESS_WIDTH'(ASSIGNED_VC);
    assign last_flit = (cnt == LAST_CNT);

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        i_ready_out = 1'b0;
        load_flit   = 1'b0;
        case (state)
            IDLE: i_ready_out = 1'b1;
            SEND: begin
                if (o_ready_in) begin
                    if (!last_flit) begin
                        cnt_next  = cnt + 1'b1;
                        load_flit = 1'b1;
                    end else begin
                        i_ready_out = 1'b1;
                        state_next  = IDLE;
                    end
                end
            end
        endcase
        accept = i_valid_in & i_ready_out;
        // A word taken during the tail flit starts the next packet without a bubble
        if (accept) begin
            state_next = SEND;
            cnt_next   = '0;
            load_flit  = 1'b1;
        end
    end

    // New words are sliced straight from the inputs so the head flit appears one cycle after accept
    flit_slicer #(
        .WIDTH_IN         (WIDTH_IN),
        .FLIT_WIDTH       (FLIT_WIDTH),
        .ADDRESS_WIDTH    (ADDRESS_WIDTH),
        .VC_ADDRESS_WIDTH (VC_ADDRESS_WIDTH),
        .CNT_W            (CNT_W)
    ) u_slicer (
        .data (accept ? i_data_in : hold_data),
        .dest (accept ? i_dest_in : hold_dest),
        .vc   (accept ? in_vc     : hold_vc),
        .cnt  (cnt_next),
        .flit (slice_flit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            hold_data   <= '0;
            hold_dest   <= '0;
            hold_vc     <= '0;
            o_data_out  <= '0;
            o_valid_out <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            o_valid_out <= (state_next == SEND);
            if (accept) begin
                hold_data <= i_data_in;
                hold_dest <= i_dest_in;
                hold_vc   <= in_vc;
            end
            if (load_flit)
                o_data_out <= slice_flit;
        end
    end

endmodule

// File: tb/tb_packetizer_serial.sv
// tb/tb_packetizer_serial.sv - directed self-checking bench for packetizer_serial
module tb_packetizer_serial;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [63:0] d_data;  logic [3:0] d_dest;  logic [0:0] d_vc;
    logic d_valid, d_iready, d_ovalid, d_oready;  logic [35:0] d_flit;
    logic [19:0] n_data;  logic [3:0] n_dest;  logic [0:0] n_vc;
    logic n_valid, n_iready, n_ovalid, n_oready;  logic [35:0] n_flit;
    logic [63:0] v_data;  logic [3:0] v_dest;  logic [0:0] v_vc;
    logic v_valid, v_iready, v_ovalid, v_oready;  logic [35:0] v_flit;

    int passed = 0;
    int total  = 0;

    packetizer_serial u_dut (
        .clk(clk), .rst(rst), .i_data_in(d_data), .i_dest_in(d_dest), .i_vc_in(d_vc),
        .i_valid_in(d_valid), .i_ready_out(d_iready), .o_data_out(d_flit),
        .o_valid_out(d_ovalid), .o_ready_in(d_oready));

    packetizer_serial #(.WIDTH_IN(20)) u_narrow (
        .clk(clk), .rst(rst), .i_data_in(n_data), .i_dest_in(n_dest), .i_vc_in(n_vc),
        .i_valid_in(n_valid), .i_ready_out(n_iready), .o_data_out(n_flit),
        .o_valid_out(n_ovalid), .o_ready_in(n_oready));

    packetizer_serial #(.VC_FROM_PORT(1)) u_vc (
        .clk(clk), .rst(rst), .i_data_in(v_data), .i_dest_in(v_dest), .i_vc_in(v_vc),
        .i_valid_in(v_valid), .i_ready_out(v_iready), .o_data_out(v_flit),
        .o_valid_out(v_ovalid), .o_ready_in(v_oready));

    task automatic test_reset();
        rst = 1'b1;
        d_data = '0; d_dest = '0; d_vc = '0; d_valid = 1'b0; d_oready = 1'b1;
        n_data = '0; n_dest = '0; n_vc = '0; n_valid = 1'b0; n_oready = 1'b1;
        v_data = '0; v_dest = '0; v_vc = '0; v_valid = 1'b0; v_oready = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (d_ovalid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", d_ovalid); else passed++;
        total++; if (d_flit !== 36'h0) $display("FAIL reset_data: got %h expected 0", d_flit); else passed++;
        total++; if (d_iready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", d_iready); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_single_packet();
        logic [35:0] f0, f1, f2;
        f0 = {3'b110, 1'b0, 4'h5, 28'hDEADBEE};
        f1 = {3'b100, 1'b0, 32'hF0123456};
        f2 = {3'b101, 1'b0, 4'h7, 28'h0};
        @(negedge clk);
        d_data = 64'hDEADBEEF_01234567; d_dest = 4'h5; d_vc = 1'b1; d_valid = 1'b1; #1;
        total++; if (d_iready !== 1'b1) $display("FAIL single_idle_ready: got %b expected 1", d_iready); else passed++;
        @(negedge clk); d_valid = 1'b0; d_data = '1; #1;
        total++; if (d_flit !== f0) $display("FAIL single_flit0: got %h expected %h", d_flit, f0); else passed++;
        total++; if (d_ovalid !== 1'b1) $display("FAIL single_valid0: got %b expected 1", d_ovalid); else passed++;
        total++; if (d_iready !== 1'b0) $display("FAIL single_ready0: got %b expected 0", d_iready); else passed++;
        @(negedge clk); #1;
        total++; if (d_flit !== f1) $display("FAIL single_flit1: got %h expected %h", d_flit, f1); else passed++;
        total++; if (d_iready !== 1'b0) $display("FAIL single_ready1: got %b expected 0", d_iready); else passed++;
        @(negedge clk); #1;
        total++; if (d_flit !== f2) $display("FAIL single_flit2: got %h expected %h", d_flit, f2); else passed++;
        total++; if (d_iready !== 1'b1) $display("FAIL single_ready2: got %b expected 1", d_iready); else passed++;
        @(negedge clk); #1;
        total++; if (d_ovalid !== 1'b0) $display("FAIL single_idle_after: got %b expected 0", d_ovalid); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] words [4];
        logic [35:0] exp;
        int k, ph;
        words[0] = 64'h0123_4567_89AB_CDEF; words[1] = 64'hFEDC_BA98_7654_3210;
        words[2] = 64'hA5A5_5A5A_C3C3_3C3C; words[3] = 64'h1357_9BDF_2468_ACE0;
        @(negedge clk);
        d_data = words[0]; d_dest = 4'h0; d_valid = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk); #1;
            k = (c - 1) / 3;
            ph = (c - 1) % 3;
            if (ph == 0)      exp = {3'b110, 1'b0, 4'(k), words[k][63:36]};
            else if (ph == 1) exp = {3'b100, 1'b0, words[k][35:4]};
            else              exp = {3'b101, 1'b0, words[k][3:0], 28'h0};
            total++; if (d_ovalid !== 1'b1) $display("FAIL b2b_valid cycle %0d: got %b expected 1", c, d_ovalid); else passed++;
            total++; if (d_flit !== exp) $display("FAIL b2b_flit cycle %0d: got %h expected %h", c, d_flit, exp); else passed++;
            if (ph == 2) begin
                if (k < 3) begin d_data = words[k+1]; d_dest = 4'(k + 1); end
                else d_valid = 1'b0;
            end
        end
        @(negedge clk); #1;
        total++; if (d_ovalid !== 1'b0) $display("FAIL b2b_end_valid: got %b expected 0", d_ovalid); else passed++;
    endtask

    task automatic test_backpressure();
        logic [35:0] f1, f2;
        f1 = {3'b100, 1'b0, 32'hC4B5A697};
        f2 = {3'b101, 1'b0, 4'h8, 28'h0};
        @(negedge clk);
        d_data = 64'h0F1E_2D3C_4B5A_6978; d_dest = 4'hA; d_valid = 1'b1;
        @(negedge clk); d_valid = 1'b0;
        @(negedge clk); #1;
        total++; if (d_flit !== f1) $display("FAIL bp_flit1: got %h expected %h", d_flit, f1); else passed++;
        d_oready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            total++; if (d_flit !== f1) $display("FAIL bp_hold cycle %0d: got %h expected %h", i, d_flit, f1); else passed++;
            total++; if (d_ovalid !== 1'b1) $display("FAIL bp_valid cycle %0d: got %b expected 1", i, d_ovalid); else passed++;
            total++; if (d_iready !== 1'b0) $display("FAIL bp_ready cycle %0d: got %b expected 0", i, d_iready); else passed++;
        end
        d_oready = 1'b1;
        @(negedge clk); #1;
        total++; if (d_flit !== f2) $display("FAIL bp_flit2: got %h expected %h", d_flit, f2); else passed++;
        total++; if (d_iready !== 1'b1) $display("FAIL bp_ready_last: got %b expected 1", d_iready); else passed++;
        @(negedge clk);
    endtask

    task automatic test_single_flit();
        logic [19:0] nw [3];
        logic [3:0]  nd [3];
        logic [35:0] exp;
        nw[0] = 20'hABCDE; nw[1] = 20'h12345; nw[2] = 20'h0F0F0;
        nd[0] = 4'h3;      nd[1] = 4'hC;      nd[2] = 4'h7;
        @(negedge clk);
        n_data = nw[0]; n_dest = nd[0]; n_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            exp = {3'b111, 1'b0, nd[i], nw[i], 8'h00};
            total++; if (n_flit !== exp) $display("FAIL narrow_flit %0d: got %h expected %h", i, n_flit, exp); else passed++;
            total++; if (n_iready !== 1'b1) $display("FAIL narrow_ready %0d: got %b expected 1", i, n_iready); else passed++;
            if (i < 2) begin n_data = nw[i+1]; n_dest = nd[i+1]; end
            else n_valid = 1'b0;
        end
        @(negedge clk); #1;
        total++; if (n_ovalid !== 1'b0) $display("FAIL narrow_idle: got %b expected 0", n_ovalid); else passed++;
    endtask

    task automatic test_vc_from_port();
        logic [35:0] head_a;
        head_a = {3'b110, 1'b1, 4'h2, 28'hCAFEF00};
        @(negedge clk);
        v_data = 64'hCAFEF00D_BAADC0DE; v_dest = 4'h2; v_vc = 1'b1; v_valid = 1'b1;
        @(negedge clk); v_valid = 1'b0; v_vc = 1'b0; v_data = '0; #1;
        total++; if (v_flit !== head_a) $display("FAIL vc_head_a: got %h expected %h", v_flit, head_a); else passed++;
        for (int i = 1; i < 3; i++) begin
            @(negedge clk); #1;
            total++; if (v_flit[32] !== 1'b1) $display("FAIL vc_a flit %0d: got %b expected 1", i, v_flit[32]); else passed++;
        end
        v_data = 64'h0123_4567_89AB_CDEF; v_dest = 4'h9; v_vc = 1'b0; v_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            v_valid = 1'b0; v_vc = 1'b1;
            total++; if (v_flit[32] !== 1'b0) $display("FAIL vc_b flit %0d: got %b expected 0", i, v_flit[32]); else passed++;
            total++; if (v_flit[34] !== (i == 0)) $display("FAIL vc_b_head flit %0d: got %b", i, v_flit[34]); else passed++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_packet();
        logic [35:0] f1, head_x;
        f1     = {3'b100, 1'b0, 32'h45566778};
        head_x = {3'b110, 1'b0, 4'h1, 28'h99AABBC};
        @(negedge clk);
        d_data = 64'h1122_3344_5566_7788; d_dest = 4'h6; d_valid = 1'b1;
        @(negedge clk); d_valid = 1'b0;
        @(negedge clk); #1;
        total++; if (d_flit !== f1) $display("FAIL rst_pre_flit1: got %h expected %h", d_flit, f1); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (d_ovalid !== 1'b0) $display("FAIL rst_async_valid: got %b expected 0", d_ovalid); else passed++;
        total++; if (d_flit !== 36'h0) $display("FAIL rst_async_data: got %h expected 0", d_flit); else passed++;
        @(negedge clk); rst = 1'b0; #1;
        total++; if (d_iready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", d_iready); else passed++;
        d_data = 64'h99AA_BBCC_DDEE_FF00; d_dest = 4'h1; d_valid = 1'b1;
        @(negedge clk); d_valid = 1'b0; #1;
        total++; if (d_flit !== head_x) $display("FAIL rst_next_head: got %h expected %h", d_flit, head_x); else passed++;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_back_to_back();
        test_backpressure();
        test_single_flit();
        test_vc_from_port();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
